button_conditioner: RTL and testbench

//  Upstream input stage between the raw board buttons (right, left, fire) and the game logic in top.
//  Per button: two-flop synchroniser into the clk125 domain, then a debounce state machine.

---
 rtl/button_conditioner_pkg.sv | 18 +
 rtl/button_conditioner_if.sv | 24 ++
 rtl/button_conditioner_debounce_fsm.sv | 91 +++++++++
 rtl/button_conditioner.sv | 78 +++++++
 tb/tb_button_conditioner.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared types and constants for the button conditioning input stage.
package button_conditioner_pkg;

   // Debounce state per button: two stable states and two arming states.
   typedef enum logic [1:0] {
      DB_IDLE   = 2'd0,
      DB_ARM_HI = 2'd1,
      DB_HELD   = 2'd2,
      DB_ARM_LO = 2'd3
   } db_state_t;

   // Bit positions of each button in the debounced level vector.
   localparam int BTN_RIGHT = 0;
   localparam int BTN_LEFT  = 1;
   localparam int BTN_FIRE  = 2;
   localparam int NUM_BTNS  = 3;

endpackage

// File: rtl/button_conditioner_if.sv
// Raw button inputs and conditioned game-control outputs as one bundle.
// The master side drives the raw buttons; the slave side is the conditioner.
interface button_conditioner_if;
   import button_conditioner_pkg::*;

   logic                right;
   logic                left;
   logic                fire;
   logic                move_right;
   logic                move_left;
   logic                fire_pulse;
   logic [NUM_BTNS-1:0] btn_level;

   modport master (
      output right, left, fire,
      input  move_right, move_left, fire_pulse, btn_level
   );

   modport slave (
      input  right, left, fire,
      output move_right, move_left, fire_pulse, btn_level
   );

endinterface

// File: rtl/button_conditioner_debounce_fsm.sv
// One button: two-flop synchroniser followed by a debounce state machine.
// A level change is accepted only after the synchronised input has held the
// new value for DEBOUNCE_CYCLES+1 consecutive samples.
module debounce_fsm
   import button_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 125_000
)
(
   input  logic clk125,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1;
   logic             s2;
   db_state_t        state;
   logic [CNT_W-1:0] cnt;

   // Bring the asynchronous button into the clk125 domain.
   always_ff @(posedge clk125) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // Debounce: arm on a change, commit once it stays stable long enough.
   always_ff @(posedge clk125) begin
      if (rst) begin
         state <= DB_IDLE;
         cnt   <= '0;
         rise  <= 1'b0;
      end else begin
         rise <= 1'b0;
         case (state)
            DB_IDLE: begin
               if (s2) begin
                  state <= DB_ARM_HI;
                  cnt   <= '0;
               end
            end
            DB_ARM_HI: begin
               if (!s2) begin
                  state <= DB_IDLE;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= DB_HELD;
                  cnt   <= '0;
                  rise  <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DB_HELD: begin
               if (!s2) begin
                  state <= DB_ARM_LO;
                  cnt   <= '0;
               end
            end
            DB_ARM_LO: begin
               if (s2) begin
                  state <= DB_HELD;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= DB_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= DB_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // The level is high while held and while a release is still being confirmed.
   assign level = (state == DB_HELD) || (state == DB_ARM_LO);

endmodule

// File: rtl/button_conditioner.sv
// Input stage between the raw board buttons and the game logic: debounces
// right/left/fire, gates the move levels so they are mutually exclusive, and
// turns the fire button into rate-limited single-cycle bullet requests.
module button_conditioner
   import button_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 125_000,
   parameter int FIRE_COOLDOWN   = 1_250_000,
   parameter bit AUTO_FIRE       = 1'b0
)
(
   input  logic                 clk125,
   input  logic                 rst,
   button_conditioner_if.slave  btn
);

   localparam int              CD_W      = $clog2(FIRE_COOLDOWN + 1);
   localparam logic [CD_W-1:0] CD_RELOAD = CD_W'(FIRE_COOLDOWN);

   logic [NUM_BTNS-1:0] raw;
   logic [NUM_BTNS-1:0] level;
   logic [NUM_BTNS-1:0] rise;
   logic [CD_W-1:0]     cd;
   logic                fire_trigger;
   logic                unused_rise;

   assign raw[BTN_RIGHT] = btn.right;
   assign raw[BTN_LEFT]  = btn.left;
   assign raw[BTN_FIRE]  = btn.fire;

   for (genvar i = 0; i < NUM_BTNS; i++) begin : g_db
      debounce_fsm #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_db (
         .clk125 (clk125),
         .rst    (rst),
         .raw    (raw[i]),
         .level  (level[i]),
         .rise   (rise[i])
      );
   end

   // Only the fire button's edge matters; the move buttons are used as levels.
   assign unused_rise = rise[BTN_RIGHT] ^ rise[BTN_LEFT];

   // Auto-fire re-triggers on the held level, otherwise only a fresh press fires.
   assign fire_trigger = AUTO_FIRE ? level[BTN_FIRE] : rise[BTN_FIRE];

   assign btn.btn_level = level;

   // Register the move outputs; pressing both buttons cancels motion.
   always_ff @(posedge clk125) begin
      if (rst) begin
         btn.move_right <= 1'b0;
         btn.move_left  <= 1'b0;
      end else begin
         btn.move_right <= level[BTN_RIGHT] & ~level[BTN_LEFT];
         btn.move_left  <= level[BTN_LEFT]  & ~level[BTN_RIGHT];
      end
   end

   // Fire only when the cooldown has expired; triggers during cooldown are dropped.
   always_ff @(posedge clk125) begin
      if (rst) begin
         cd             <= '0;
         btn.fire_pulse <= 1'b0;
      end else if (fire_trigger && (cd == '0)) begin
         cd             <= CD_RELOAD;
         btn.fire_pulse <= 1'b1;
      end else begin
         btn.fire_pulse <= 1'b0;
         if (cd != '0) begin
            cd <= cd - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: two instances (single-shot and auto-fire) share
// the same button stimulus and are checked every cycle against a reference
// model, plus directed table vectors and hand-written corner-case sequences.
module tb_button_conditioner;
   import button_conditioner_pkg::*;

   localparam int DB = 4;
   localparam int CD = 20;

   typedef struct {
      string      name;
      bit         r;
      bit         l;
      bit         f;
      int         cycles;
      logic [2:0] exp_level;
      logic       exp_mr;
      logic       exp_ml;
      int         exp_pulses;
   } vec_t;

   logic clk125   = 1'b0;
   logic rst      = 1'b1;
   logic right_in = 1'b0;
   logic left_in  = 1'b0;
   logic fire_in  = 1'b0;

   int n_compared   = 0;
   int n_mismatched = 0;
   int pulses_man   = 0;
   int pulses_auto  = 0;

   // Reference model state: debounced levels and the length of the current
   // run of synchronised samples that disagree with them.
   bit m_p1  [3];
   bit m_p2  [3];
   bit m_lvl [3];
   int m_run [3];
   bit m_rise_pending;
   int m_last_pulse [2];
   bit exp_mr;
   bit exp_ml;
   bit exp_fp [2];
   int edge_no = 0;

   always #4 clk125 = ~clk125;

   button_conditioner_if bus_man ();
   button_conditioner_if bus_auto ();

   assign bus_man.right  = right_in;
   assign bus_man.left   = left_in;
   assign bus_man.fire   = fire_in;
   assign bus_auto.right = right_in;
   assign bus_auto.left  = left_in;
   assign bus_auto.fire  = fire_in;

   button_conditioner #(
      .DEBOUNCE_CYCLES (DB),
      .FIRE_COOLDOWN   (CD),
      .AUTO_FIRE       (1'b0)
   ) dut_man (
      .clk125 (clk125),
      .rst    (rst),
      .btn    (bus_man)
   );

   button_conditioner #(
      .DEBOUNCE_CYCLES (DB),
      .FIRE_COOLDOWN   (CD),
      .AUTO_FIRE       (1'b1)
   ) dut_auto (
      .clk125 (clk125),
      .rst    (rst),
      .btn    (bus_auto)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", name, edge_no, actual, expected);
      end
   endtask

   task automatic applyStimulus(input bit r, input bit l, input bit f);
      right_in = r;
      left_in  = l;
      fire_in  = f;
   endtask

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic modelStep();
      bit raw [3];
      bit trig;
      raw[BTN_RIGHT] = right_in;
      raw[BTN_LEFT]  = left_in;
      raw[BTN_FIRE]  = fire_in;
      edge_no++;
      if (rst) begin
         for (int b = 0; b < 3; b++) begin
            m_p1[b]  = 1'b0;
            m_p2[b]  = 1'b0;
            m_lvl[b] = 1'b0;
            m_run[b] = 0;
         end
         m_rise_pending = 1'b0;
         exp_mr = 1'b0;
         exp_ml = 1'b0;
         for (int k = 0; k < 2; k++) begin
            m_last_pulse[k] = -1000;
            exp_fp[k]       = 1'b0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            trig = (k == 1) ? m_lvl[BTN_FIRE] : m_rise_pending;
            exp_fp[k] = trig && ((edge_no - m_last_pulse[k]) > CD);
            if (exp_fp[k]) m_last_pulse[k] = edge_no;
         end
         exp_mr = m_lvl[BTN_RIGHT] && !m_lvl[BTN_LEFT];
         exp_ml = m_lvl[BTN_LEFT] && !m_lvl[BTN_RIGHT];
         m_rise_pending = 1'b0;
         for (int b = 0; b < 3; b++) begin
            if (m_p2[b] != m_lvl[b]) begin
               m_run[b]++;
               if (m_run[b] == DB + 1) begin
                  m_lvl[b] = m_p2[b];
                  m_run[b] = 0;
                  if (b == BTN_FIRE && m_lvl[b]) m_rise_pending = 1'b1;
               end
            end else begin
               m_run[b] = 0;
            end
            m_p2[b] = m_p1[b];
            m_p1[b] = raw[b];
         end
      end
   endtask

   task automatic compareAll();
      logic [2:0] lv;
      lv = {m_lvl[BTN_FIRE], m_lvl[BTN_LEFT], m_lvl[BTN_RIGHT]};
      checkOutput("man_btn_level",   bus_man.btn_level,   lv);
      checkOutput("man_move_right",  bus_man.move_right,  exp_mr);
      checkOutput("man_move_left",   bus_man.move_left,   exp_ml);
      checkOutput("man_fire_pulse",  bus_man.fire_pulse,  exp_fp[0]);
      checkOutput("auto_btn_level",  bus_auto.btn_level,  lv);
      checkOutput("auto_move_right", bus_auto.move_right, exp_mr);
      checkOutput("auto_move_left",  bus_auto.move_left,  exp_ml);
      checkOutput("auto_fire_pulse", bus_auto.fire_pulse, exp_fp[1]);
   endtask

   task automatic tick();
      @(posedge clk125);
      modelStep();
      @(negedge clk125);
      compareAll();
      if (bus_man.fire_pulse === 1'b1) pulses_man++;
      if (bus_auto.fire_pulse === 1'b1) pulses_auto++;
   endtask

   task automatic doReset(input int n);
      rst = 1'b1;
      for (int i = 0; i < n; i++) tick();
      rst = 1'b0;
   endtask

   vec_t vecs [12];
   int   pulse_t [$];

   initial begin
      $display("[TB] start");

      // Reset with all buttons held: outputs stay 0, then a fresh press follows.
      applyStimulus(1'b1, 1'b1, 1'b1);
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("rst_level", bus_man.btn_level, 3'b000);
         checkOutput("rst_moves", {bus_man.move_right, bus_man.move_left}, 2'b00);
         checkOutput("rst_pulse", bus_man.fire_pulse, 1'b0);
      end
      rst = 1'b0;
      pulses_man = 0;
      for (int i = 0; i < 6; i++) tick();
      checkOutput("t1_level_before", bus_man.btn_level, 3'b000);
      tick();
      checkOutput("t1_level_after", bus_man.btn_level, 3'b111);
      for (int i = 0; i < 8; i++) tick();
      checkOutput("t1_pulse_count", pulses_man, 1);
      checkOutput("t1_moves", {bus_man.move_right, bus_man.move_left}, 2'b00);

      // Table-driven segments: inputs held for a number of cycles, then checked.
      applyStimulus(1'b0, 1'b0, 1'b0);
      doReset(2);
      vecs[0]  = '{"idle",          0, 0, 0,  5, 3'b000, 0, 0, 0};
      vecs[1]  = '{"right_press",   1, 0, 0, 10, 3'b001, 1, 0, 0};
      vecs[2]  = '{"both_pressed",  1, 1, 0, 10, 3'b011, 0, 0, 0};
      vecs[3]  = '{"left_only",     0, 1, 0, 10, 3'b010, 0, 1, 0};
      vecs[4]  = '{"right_glitch",  1, 1, 0,  4, 3'b010, 0, 1, 0};
      vecs[5]  = '{"release_all",   0, 0, 0, 10, 3'b000, 0, 0, 0};
      vecs[6]  = '{"fire_glitch4",  0, 0, 1,  4, 3'b000, 0, 0, 0};
      vecs[7]  = '{"quiet",         0, 0, 0, 10, 3'b000, 0, 0, 0};
      vecs[8]  = '{"fire_5",        0, 0, 1,  5, 3'b000, 0, 0, 0};
      vecs[9]  = '{"after_fire_5",  0, 0, 0, 12, 3'b000, 0, 0, 1};
      vecs[10] = '{"right_80",      1, 0, 0, 80, 3'b001, 1, 0, 0};
      vecs[11] = '{"right_release", 0, 0, 0, 10, 3'b000, 0, 0, 0};
      for (int v = 0; v < 12; v++) begin
         applyStimulus(vecs[v].r, vecs[v].l, vecs[v].f);
         pulses_man = 0;
         for (int c = 0; c < vecs[v].cycles; c++) tick();
         checkOutput({vecs[v].name, "_level"},  bus_man.btn_level,  vecs[v].exp_level);
         checkOutput({vecs[v].name, "_mright"}, bus_man.move_right, vecs[v].exp_mr);
         checkOutput({vecs[v].name, "_mleft"},  bus_man.move_left,  vecs[v].exp_ml);
         checkOutput({vecs[v].name, "_pulses"}, pulses_man,         vecs[v].exp_pulses);
      end

      // Second press inside the cooldown is dropped; a later press fires again.
      applyStimulus(1'b0, 1'b0, 1'b0);
      doReset(2);
      pulse_t.delete();
      for (int t = 0; t < 70; t++) begin
         applyStimulus(1'b0, 1'b0, (t < 6) || (t >= 12 && t < 18) || (t >= 40 && t < 46));
         tick();
         if (bus_man.fire_pulse === 1'b1) pulse_t.push_back(t);
      end
      checkOutput("cooldown_pulse_count", pulse_t.size(), 2);
      if (pulse_t.size() == 2) begin
         checkOutput("cooldown_first_at", pulse_t[0], 7);
         checkOutput("cooldown_second_at", pulse_t[1], 47);
      end

      // Auto-fire with the button held: evenly spaced pulses.
      applyStimulus(1'b0, 1'b0, 1'b0);
      doReset(2);
      pulse_t.delete();
      pulses_man = 0;
      for (int t = 0; t < 120; t++) begin
         applyStimulus(1'b0, 1'b0, t < 100);
         tick();
         if (bus_auto.fire_pulse === 1'b1) pulse_t.push_back(t);
      end
      checkOutput("auto_pulse_count", pulse_t.size(), (100 - 7) / 21 + 1);
      checkOutput("held_single_pulse", pulses_man, 1);
      if (pulse_t.size() > 0) checkOutput("auto_first_at", pulse_t[0], 7);
      for (int i = 1; i < pulse_t.size(); i++)
         checkOutput("auto_spacing", pulse_t[i] - pulse_t[i-1], 21);

      // Left held, right pressed mid-hold, then reset while left stays held.
      applyStimulus(1'b0, 1'b0, 1'b0);
      doReset(2);
      for (int t = 0; t < 60; t++) begin
         applyStimulus((t >= 20) && (t < 40), 1'b1, 1'b0);
         tick();
         checkOutput("t6_no_right", bus_man.move_right, 1'b0);
         if (t == 19) checkOutput("t6_left_on", bus_man.move_left, 1'b1);
         if (t == 26) checkOutput("t6_left_before_drop", bus_man.move_left, 1'b1);
         if (t == 27) checkOutput("t6_left_dropped", bus_man.move_left, 1'b0);
         if (t == 46) checkOutput("t6_left_still_off", bus_man.move_left, 1'b0);
         if (t == 47) checkOutput("t6_left_back", bus_man.move_left, 1'b1);
      end
      rst = 1'b1;
      tick();
      checkOutput("t6_rst_moves", {bus_man.move_right, bus_man.move_left}, 2'b00);
      checkOutput("t6_rst_level", bus_man.btn_level, 3'b000);
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      checkOutput("t6_rearm_wait", bus_man.move_left, 1'b0);
      tick();
      checkOutput("t6_rearm_left", bus_man.move_left, 1'b1);

      // Random button activity with occasional resets, checked against the model.
      for (int seg = 0; seg < 90; seg++) begin
         if ($urandom_range(0, 19) == 0) begin
            doReset($urandom_range(1, 2));
         end
         applyStimulus($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
         for (int c = 0, n = $urandom_range(1, 14); c < n; c++) tick();
      end
      applyStimulus(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 30; i++) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
